axis_fifo: RTL



---
 rtl/axis_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with first-word-fall-through output and an optional packet mode
// that holds egress until a complete packet (tlast) is stored.
module axis_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,

  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,

  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = USER_WIDTH + DEST_WIDTH + ID_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WW-1:0]  mem [DEPTH];
  logic [WW-1:0]  s_word;
  logic [WW-1:0]  m_word;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic           fallback_q, fallback_d;

  logic           push;
  logic           pop;
  logic           full_w;
  logic           empty_w;
  logic           push_last;
  logic           pop_last;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Ready depends only on stored state, never on the downstream ready.
  assign s_axis_tready = !full_w;

  // In packet mode a full FIFO with no complete packet would deadlock, so it
  // releases beats cut-through until the partial packet's tlast leaves.
  assign m_axis_tvalid = !empty_w &&
                         (PACKET_MODE == 0 || pkt_cnt_q != '0 || full_w || fallback_q);

  assign push      = s_axis_tvalid && s_axis_tready;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && m_axis_tlast;

  assign s_word = {s_axis_tuser, s_axis_tdest, s_axis_tid,
                   s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign m_word = mem[rd_ptr_q];
  assign {m_axis_tuser, m_axis_tdest, m_axis_tid,
          m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_word;

  assign count = count_q;
  assign full  = full_w;
  assign empty = empty_w;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pkt_cnt_d  = pkt_cnt_q;
    fallback_d = fallback_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    if (full_w && pkt_cnt_q == '0) fallback_d = 1'b1;
    if (pop_last)                  fallback_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      fallback_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pkt_cnt_q  <= pkt_cnt_d;
      fallback_q <= fallback_d;
    end
  end

  // Payload storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_word;
  end

endmodule
